// File: rtl/mp_addsub_seq.sv
// rtl/mp_addsub_seq.sv - slice-serial multi-precision adder/subtractor/comparator
//
// Processes OPERAND_WIDTH-bit operands ADDER_WIDTH bits per cycle through one
// narrow adder and a registered carry. N = OPERAND_WIDTH/ADDER_WIDTH slices,
// start-to-done latency N+1 cycles, back-to-back start accepted in DONE.
//
// Optional feature macro: MP_ADDSUB_OVF_EN (adds oOvf signed-overflow flag).
//
// Ports:
//   iClk    clock, rising edge
//   iRstN   asynchronous active-low reset
//   iStart  start request, accepted in IDLE and DONE
//   iMode   00 ADD, 01 SUB, 10 ADDC, 11 CMP
//   iCarry  carry-in for ADDC
//   iOpA    operand A
//   iOpB    operand B
//   oRes    result; top bit is carry-out (ADD/ADDC) or sign of A-B (SUB/CMP)
//   oDone   one-cycle result-valid pulse
//   oBusy   calculation in progress
//   oZero   low OPERAND_WIDTH bits of result are zero
//   oOvf    signed overflow of the OPERAND_WIDTH-bit result (MP_ADDSUB_OVF_EN only)
//   oLt     unsigned A<B for SUB/CMP, 0 for ADD/ADDC

module mp_addsub_seq #(
    parameter int OPERAND_WIDTH = 128,
    parameter int ADDER_WIDTH   = 32
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic                     iStart,
    input  logic [1:0]               iMode,
    input  logic                     iCarry,
    input  logic [OPERAND_WIDTH-1:0] iOpA,
    input  logic [OPERAND_WIDTH-1:0] iOpB,
    output logic [OPERAND_WIDTH:0]   oRes,
    output logic                     oDone,
    output logic                     oBusy,
    output logic                     oZero,
`ifdef MP_ADDSUB_OVF_EN
    output logic                     oOvf,
`endif
    output logic                     oLt
);

    localparam int W  = OPERAND_WIDTH;
    localparam int AW = ADDER_WIDTH;
    localparam int N  = OPERAND_WIDTH / ADDER_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] MODE_ADDC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;     // holds ~B for SUB/CMP
    logic [W-1:0]    res_sr;
    logic            carry_q;
    logic            sub_q;     // SUB and CMP both have iMode[0]=1
    logic [CW-1:0]   cnt;

    logic [AW:0]     slice_sum;
    logic [W-1:0]    sum_top;
    logic [W-1:0]    res_next;
    logic            last_slice;

    // Operand registers shift right each CALC cycle, so the current slice is
    // always the low ADDER_WIDTH bits.
    always_comb begin
        slice_sum  = {1'b0, a_reg[AW-1:0]} + {1'b0, b_reg[AW-1:0]} + {{AW{1'b0}}, carry_q};
        sum_top    = W'(slice_sum[AW-1:0]) << (W - AW);
        res_next   = (res_sr >> AW) | sum_top;
        last_slice = (cnt == CW'(N - 1));
    end

`ifdef MP_ADDSUB_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit and its two inputs;
    // only meaningful on the last slice, where it is consumed.
    logic msb_cin;
    always_comb begin
        msb_cin = a_reg[AW-1] ^ b_reg[AW-1] ^ slice_sum[AW-1];
    end
`endif

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt     <= '0;
            oRes    <= '0;
            oDone   <= 1'b0;
            oBusy   <= 1'b0;
            oZero   <= 1'b0;
            oLt     <= 1'b0;
`ifdef MP_ADDSUB_OVF_EN
            oOvf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        a_reg   <= iOpA;
                        b_reg   <= iMode[0] ? ~iOpB : iOpB;
                        carry_q <= iMode[0] ? 1'b1 : ((iMode == MODE_ADDC) ? iCarry : 1'b0);
                        sub_q   <= iMode[0];
                        cnt     <= '0;
                        oBusy   <= 1'b1;
                        state   <= CALC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    a_reg   <= a_reg >> AW;
                    b_reg   <= b_reg >> AW;
                    carry_q <= slice_sum[AW];
                    res_sr  <= res_next;
                    cnt     <= cnt + CW'(1);
                    if (last_slice) begin
                        // Subtraction is A + ~B + 1: no final carry means a borrow.
                        oRes  <= {sub_q ? ~slice_sum[AW] : slice_sum[AW], res_next};
                        oZero <= (res_next == '0);
                        oLt   <= sub_q & ~slice_sum[AW];
`ifdef MP_ADDSUB_OVF_EN
                        oOvf  <= msb_cin ^ slice_sum[AW];
`endif
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// tb/tb_mp_addsub_seq.sv - self-checking bench for mp_addsub_seq
module tb_mp_addsub_seq;

    localparam int W  = 128;
    localparam int AW = 32;
    localparam int N  = W / AW;
    localparam int RW = W + 1;

    logic          iClk;
    logic          iRstN;
    logic          iStart;
    logic [1:0]    iMode;
    logic          iCarry;
    logic [W-1:0]  iOpA;
    logic [W-1:0]  iOpB;
    logic [W:0]    oRes;
    logic          oDone;
    logic          oBusy;
    logic          oZero;
    logic          oLt;
`ifdef MP_ADDSUB_OVF_EN
    logic          oOvf;
`endif

    mp_addsub_seq #(.OPERAND_WIDTH(W), .ADDER_WIDTH(AW)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iStart (iStart),
        .iMode  (iMode),
        .iCarry (iCarry),
        .iOpA   (iOpA),
        .iOpB   (iOpB),
        .oRes   (oRes),
        .oDone  (oDone),
        .oBusy  (oBusy),
        .oZero  (oZero),
`ifdef MP_ADDSUB_OVF_EN
        .oOvf   (oOvf),
`endif
        .oLt    (oLt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    always @(negedge iClk) if (oDone === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operation definitions.
    typedef struct {
        logic [W:0] res;
        logic       lt;
        logic       zero;
        logic       ovf;
    } ref_t;

    function automatic ref_t model(input logic [1:0] m, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic c);
        ref_t r;
        logic [W+1:0] sa, sb, s;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        case (m)
            2'b00: begin r.res = {1'b0, a} + {1'b0, b};                s = sa + sb; end
            2'b10: begin r.res = {1'b0, a} + {1'b0, b} + RW'(c);       s = sa + sb + (W+2)'(c); end
            default: begin r.res = {1'b0, a} - {1'b0, b};              s = sa - sb; end
        endcase
        r.lt   = m[0] && (a < b);
        r.zero = (r.res[W-1:0] == '0);
        r.ovf  = !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
        return r;
    endfunction

    task automatic start_op(input logic [1:0] m, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic c);
        @(negedge iClk);
        iStart = 1'b1; iMode = m; iOpA = a; iOpB = b; iCarry = c;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    // idx counts negedges since the sampling edge; 1 is the first after it.
    task automatic wait_done(output int idx);
        idx = 1;
        while (oDone !== 1'b1 && idx < 40) begin
            @(negedge iClk);
            idx++;
        end
    endtask

    task automatic check_res(input string tag, input ref_t e);
        check({tag, ".res"},  oRes, e.res);
        check({tag, ".zero"}, RW'(oZero), RW'(e.zero));
        check({tag, ".lt"},   RW'(oLt), RW'(e.lt));
`ifdef MP_ADDSUB_OVF_EN
        check({tag, ".ovf"},  RW'(oOvf), RW'(e.ovf));
`endif
    endtask

    task automatic do_op(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        int idx;
        start_op(m, a, b, c);
        check({tag, ".busy"}, RW'(oBusy), RW'(1));
        wait_done(idx);
        check({tag, ".lat"}, RW'(idx), RW'(N + 1));
        check({tag, ".busy_done"}, RW'(oBusy), RW'(0));
        check_res(tag, model(m, a, b, c));
    endtask

    initial begin
        logic [W-1:0] a, b, ones;
        logic [W:0]   exp_res;
        logic [1:0]   m;
        logic         c;
        ref_t         e1, e2;
        int           idx, d0;

        iRstN = 1'b0; iStart = 1'b0; iMode = 2'b00; iCarry = 1'b0; iOpA = '0; iOpB = '0;
        repeat (3) @(negedge iClk);
        check("rst.res",  oRes, '0);
        check("rst.done", RW'(oDone), RW'(0));
        check("rst.busy", RW'(oBusy), RW'(0));
        check("rst.zero", RW'(oZero), RW'(0));
        check("rst.lt",   RW'(oLt), RW'(0));
        iRstN = 1'b1;
        @(negedge iClk);

        // SUB 10^28 - 5*10^27
        do_op("sub_big", 2'b01, 128'd10000000000000000000000000000,
              128'd5000000000000000000000000000, 1'b0);
        check("sub_big.const", oRes, 129'd5000000000000000000000000000);

        // SUB 5 - 7
        do_op("sub_neg", 2'b01, 128'd5, 128'd7, 1'b0);
        exp_res = '1; exp_res[0] = 1'b0;
        check("sub_neg.const", oRes, exp_res);
        check("sub_neg.lt1", RW'(oLt), RW'(1));

        // ADD wrap-around
        ones = '1;
        do_op("add_wrap", 2'b00, ones, 128'd1, 1'b0);
        exp_res = '0; exp_res[W] = 1'b1;
        check("add_wrap.const", oRes, exp_res);
        check("add_wrap.zero1", RW'(oZero), RW'(1));

        // ADDC with carry-in, ADD ignoring carry-in
        do_op("addc", 2'b10, '0, '0, 1'b1);
        check("addc.const", oRes, 129'd1);
        do_op("add_nocin", 2'b00, 128'd3, 128'd4, 1'b1);
        check("add_nocin.const", oRes, 129'd7);

        // CMP equal
        do_op("cmp_eq", 2'b11, 128'hDEADBEEF, 128'hDEADBEEF, 1'b0);
        check("cmp_eq.zero1", RW'(oZero), RW'(1));
        check("cmp_eq.lt0", RW'(oLt), RW'(0));

        // Randomised operations, with equal and carry-boundary operands mixed in
        for (int i = 0; i < 24; i++) begin
            m = 2'($urandom_range(0, 3));
            c = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (i % 6 == 1) b = a;
            if (i % 6 == 3) b = ~a;
            if (i % 6 == 5) a = {a[W-1:AW], {AW{1'b1}}};
            do_op($sformatf("rnd%0d", i), m, a, b, c);
        end

        // Back-to-back: start held during DONE
        e1 = model(2'b00, 128'd100, 128'd23, 1'b0);
        e2 = model(2'b01, 128'd9, 128'd11, 1'b0);
        start_op(2'b00, 128'd100, 128'd23, 1'b0);
        wait_done(idx);
        check("b2b.lat1", RW'(idx), RW'(N + 1));
        iStart = 1'b1; iMode = 2'b01; iOpA = 128'd9; iOpB = 128'd11; iCarry = 1'b0;
        check_res("b2b.op1", e1);
        @(negedge iClk);
        iStart = 1'b0;
        check("b2b.busy2", RW'(oBusy), RW'(1));
        check("b2b.hold", oRes, e1.res);
        wait_done(idx);
        check("b2b.lat2", RW'(idx), RW'(N + 1));
        check_res("b2b.op2", e2);

        // Start pulsed during CALC is ignored
        e1 = model(2'b10, 128'd1000, 128'd2000, 1'b1);
        start_op(2'b10, 128'd1000, 128'd2000, 1'b1);
        @(negedge iClk);
        iStart = 1'b1; iMode = 2'b00; iOpA = 128'd1; iOpB = 128'd1;
        @(negedge iClk);
        iStart = 1'b0;
        d0 = done_cnt;
        repeat (3 * N) @(negedge iClk);
        check("ign.done_cnt", RW'(done_cnt - d0), RW'(1));
        check_res("ign", e1);

        // Reset during CALC slice k=2
        start_op(2'b00, ones, ones, 1'b0);
        repeat (2) @(negedge iClk);
        d0 = done_cnt;
        iRstN = 1'b0;
        #1;
        check("abort.res",  oRes, '0);
        check("abort.busy", RW'(oBusy), RW'(0));
        check("abort.done", RW'(oDone), RW'(0));
        check("abort.zero", RW'(oZero), RW'(0));
        check("abort.lt",   RW'(oLt), RW'(0));
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        repeat (3 * N) @(negedge iClk);
        check("abort.no_done", RW'(done_cnt - d0), RW'(0));
        do_op("after_rst", 2'b11, 128'd42, 128'd99, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mp_addsub_seq.md
# mp_addsub_seq

Parametrised multi-precision adder/subtractor/comparator. It processes OPERAND_WIDTH-bit operands in ADDER_WIDTH-bit slices over successive cycles, using one narrow adder and a registered carry chain. It supersedes the fixed add/sub multi-precision adder in the arithmetic datapath. It adds these features:
- carry-in chaining for operands wider than OPERAND_WIDTH;
- a compare mode with zero and less-than flags;
- back-to-back start acceptance.

## Interface
Parameters:
- OPERAND_WIDTH, 128, operand width in bits. Must be an integer multiple of ADDER_WIDTH.
- ADDER_WIDTH, 32, slice width processed per cycle. N = OPERAND_WIDTH/ADDER_WIDTH slices.

Ports:
- iClk  in  1  clock, rising edge.
- iRstN  in  1  reset, asynchronous assert, active-low.
- iStart  in  1  start request. Sampled on rising edge when oBusy=0.
- iMode  in  2  operation: 00 ADD, 01 SUB, 10 ADDC (add with iCarry), 11 CMP.
- iCarry  in  1  carry-in. Used only in ADDC.
- iOpA, iOpB  in  OPERAND_WIDTH  operands. Sampled with iStart.
- oRes  out  OPERAND_WIDTH+1  result. For ADD/ADDC, bit[OPERAND_WIDTH] is carry-out. For SUB/CMP, the result is A−B as a two's-complement (OPERAND_WIDTH+1)-bit value.
- oDone  out  1  one-cycle pulse: result valid.
- oBusy  out  1  high while a calculation is in progress.
- oZero  out  1  oRes[OPERAND_WIDTH-1:0]==0. Updated with oDone.
- oLt  out  1  unsigned A<B. Valid for SUB/CMP; 0 for ADD/ADDC.

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE.
- Reset: all outputs are 0, slice counter is 0, and operand registers are cleared.
- Start acceptance: iStart is accepted in IDLE and in DONE. It is ignored in CALC.
- On acceptance:
  - latch A, and latch B' = ~B for SUB/CMP or B otherwise;
  - set initial carry: 1 for SUB/CMP, iCarry for ADDC, 0 for ADD;
  - latch mode, clear the slice counter, go to CALC.
- CALC cycle k (k=0..N−1):
  - add slice k of A and B' plus the registered carry;
  - shift the ADDER_WIDTH sum into the result shift register from the top;
  - register the carry-out.
- CALC exit: at k=N−1, go to DONE.
- Result top bit on entry to DONE:
  - ADD/ADDC: oRes[OPERAND_WIDTH] = final carry.
  - SUB/CMP: oRes[OPERAND_WIDTH] = ~final carry (borrow), and oLt = ~final carry.
- DONE lasts one cycle with oDone=1, then returns to IDLE. If iStart is accepted in DONE, it goes directly to CALC.
- Result hold: oRes, oZero and oLt hold until the next DONE. They are not cleared by a new start.
- CMP computes exactly as SUB. Its result is also placed on oRes.
- Wrap-around: ADD of all-ones plus 1 gives oRes[OPERAND_WIDTH-1:0]=0, carry bit = 1, oZero=1.
- Reset mid-operation: the calculation is aborted immediately. No oDone is produced.

## Timing
- Start to done: iStart is sampled at edge t. oBusy=1 from after edge t to after edge t+N. oDone=1 for exactly the cycle after edge t+N.
- Latency is N+1 cycles from the sampling edge to oDone high.
- Throughput: one operation per N+1 cycles with back-to-back starts. For the next operation, iStart is held high during the DONE cycle.
- Output changes: outputs change only on rising edges, except the asynchronous reset.
- Critical path: one ADDER_WIDTH adder plus the carry register.

## Configuration
- MP_ADDSUB_OVF_EN defined:
  - adds output port oOvf (1 bit), registered with oDone;
  - oOvf is signed two's-complement overflow of the OPERAND_WIDTH-bit result: the carry into the MSB XOR the carry out of the MSB, for all modes;
  - oOvf resets to 0.
- MP_ADDSUB_OVF_EN undefined: the port and its logic are absent.

## Test plan
- SUB, A=10^28, B=5·10^27 → after N+1 cycles oDone pulses; oRes=5·10^27, bit[128]=0, oLt=0, oZero=0.
- SUB, A=5, B=7 → oRes = 2^129−2 (all-ones except LSB, 129 bits), oLt=1.
- ADD, A=2^128−1, B=1 → oRes[127:0]=0, oRes[128]=1, oZero=1. With MP_ADDSUB_OVF_EN defined, oOvf=0.
- ADDC, A=0, B=0, iCarry=1 → oRes=1. CMP, A=B=0xDEADBEEF → oZero=1, oLt=0.
- Back-to-back: iStart held high through DONE with new operands → second oDone exactly N+1 cycles after the first. iStart pulsed during CALC → ignored, and only one oDone results.
- iRstN low at CALC cycle k=2 → all outputs 0 at once, no oDone. A new start after release → correct result.
